// File: rtl/rename_rat.sv
// Two-wide register rename stage with a speculative and an architectural RAT.
// Pops new physical tags at rename, returns stale tags at commit and restores
// the speculative map from the architectural map on an exception.
module rename_rat #(
  parameter int unsigned ARCH_REG_NUM   = 32,
  parameter int unsigned ARCH_REG_WIDTH = 5,
  parameter int unsigned PHY_REG_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  // rename bundle
  input  logic                      rn_valid_first_i,
  input  logic                      rn_valid_second_i,
  output logic                      rn_ready_o,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rs1_first_i,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rs2_first_i,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rd_first_i,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rs1_second_i,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rs2_second_i,
  input  logic [ARCH_REG_WIDTH-1:0] rn_rd_second_i,
  input  logic                      rn_rd_wen_first_i,
  input  logic                      rn_rd_wen_second_i,
  // downstream
  input  logic                      ds_ready_i,
  output logic                      out_valid_first_o,
  output logic                      out_valid_second_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prs1_first_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prs2_first_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prd_first_o,
  output logic [PHY_REG_WIDTH-1:0]  out_old_prd_first_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prs1_second_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prs2_second_o,
  output logic [PHY_REG_WIDTH-1:0]  out_prd_second_o,
  output logic [PHY_REG_WIDTH-1:0]  out_old_prd_second_o,
  // freelist
  output logic                      fl_rd_first_en_o,
  output logic                      fl_rd_second_en_o,
  input  logic [PHY_REG_WIDTH-1:0]  fl_rdata_first_i,
  input  logic [PHY_REG_WIDTH-1:0]  fl_rdata_second_i,
  input  logic                      fl_empty_i,
  input  logic                      fl_almost_empty_i,
  output logic                      fl_wr_first_en_o,
  output logic                      fl_wr_second_en_o,
  output logic [PHY_REG_WIDTH-1:0]  fl_wdata_first_o,
  output logic [PHY_REG_WIDTH-1:0]  fl_wdata_second_o,
  output logic                      fl_rd_excep_first_en_o,
  output logic                      fl_rd_excep_second_en_o,
  output logic                      fl_excep_rst_o,
  // commit
  input  logic                      cmt_valid_first_i,
  input  logic                      cmt_valid_second_i,
  input  logic                      cmt_rd_wen_first_i,
  input  logic                      cmt_rd_wen_second_i,
  input  logic [ARCH_REG_WIDTH-1:0] cmt_rd_first_i,
  input  logic [ARCH_REG_WIDTH-1:0] cmt_rd_second_i,
  input  logic [PHY_REG_WIDTH-1:0]  cmt_prd_first_i,
  input  logic [PHY_REG_WIDTH-1:0]  cmt_prd_second_i,
  input  logic [PHY_REG_WIDTH-1:0]  cmt_old_prd_first_i,
  input  logic [PHY_REG_WIDTH-1:0]  cmt_old_prd_second_i,
  input  logic                      excep_i
);

  logic [PHY_REG_WIDTH-1:0] srat_q [ARCH_REG_NUM];
  logic [PHY_REG_WIDTH-1:0] srat_d [ARCH_REG_NUM];
  logic [PHY_REG_WIDTH-1:0] arat_q [ARCH_REG_NUM];
  logic [PHY_REG_WIDTH-1:0] arat_d [ARCH_REG_NUM];

  logic                     out_valid_first_q, out_valid_second_q;
  logic [PHY_REG_WIDTH-1:0] prs1_first_q, prs2_first_q, prd_first_q, old_first_q;
  logic [PHY_REG_WIDTH-1:0] prs1_second_q, prs2_second_q, prd_second_q, old_second_q;

  logic                     fire, alloc_first, alloc_second, cmt_first, cmt_second;
  logic [PHY_REG_WIDTH-1:0] prs1_first, prs2_first, prd_first, old_first;
  logic [PHY_REG_WIDTH-1:0] prs1_second, prs2_second, prd_second, old_second;

  // Empty is implied by almost-empty; kept in the term so both flags are honoured.
  assign rn_ready_o = !excep_i & (ds_ready_i | !out_valid_first_q) &
                      !fl_almost_empty_i & !fl_empty_i;
  assign fire       = rn_valid_first_i & rn_ready_o;

  assign alloc_first  = rn_valid_first_i & rn_rd_wen_first_i & (rn_rd_first_i != '0);
  assign alloc_second = rn_valid_second_i & rn_rd_wen_second_i & (rn_rd_second_i != '0);

  // First allocation always takes the first freelist port.
  assign fl_rd_first_en_o  = fire & (alloc_first | alloc_second);
  assign fl_rd_second_en_o = fire & alloc_first & alloc_second;

  // Rename lookup with slot-1 to slot-2 bypass.
  always_comb begin
    prd_first   = alloc_first ? fl_rdata_first_i : '0;
    prd_second  = alloc_second ? (alloc_first ? fl_rdata_second_i : fl_rdata_first_i) : '0;
    prs1_first  = (rn_rs1_first_i == '0) ? '0 : srat_q[rn_rs1_first_i];
    prs2_first  = (rn_rs2_first_i == '0) ? '0 : srat_q[rn_rs2_first_i];
    old_first   = alloc_first ? srat_q[rn_rd_first_i] : '0;
    prs1_second = (rn_rs1_second_i == '0) ? '0 : srat_q[rn_rs1_second_i];
    prs2_second = (rn_rs2_second_i == '0) ? '0 : srat_q[rn_rs2_second_i];
    old_second  = alloc_second ? srat_q[rn_rd_second_i] : '0;
    if (alloc_first && rn_rs1_second_i == rn_rd_first_i) prs1_second = prd_first;
    if (alloc_first && rn_rs2_second_i == rn_rd_first_i) prs2_second = prd_first;
    if (alloc_second && alloc_first && rn_rd_second_i == rn_rd_first_i) old_second = prd_first;
  end

  // Commit: update aRAT, return stale tags compacted onto the first port.
  assign cmt_first  = cmt_valid_first_i & cmt_rd_wen_first_i & (cmt_rd_first_i != '0);
  assign cmt_second = cmt_valid_second_i & cmt_rd_wen_second_i & (cmt_rd_second_i != '0);

  assign fl_wr_first_en_o        = cmt_first | cmt_second;
  assign fl_wr_second_en_o       = cmt_first & cmt_second;
  assign fl_wdata_first_o        = cmt_first ? cmt_old_prd_first_i : cmt_old_prd_second_i;
  assign fl_wdata_second_o       = cmt_old_prd_second_i;
  assign fl_rd_excep_first_en_o  = fl_wr_first_en_o;
  assign fl_rd_excep_second_en_o = fl_wr_second_en_o;
  assign fl_excep_rst_o          = excep_i;

  // Next-state for both maps; slot 2 applied last so it wins on equal rds.
  always_comb begin
    arat_d = arat_q;
    if (cmt_first)  arat_d[cmt_rd_first_i]  = cmt_prd_first_i;
    if (cmt_second) arat_d[cmt_rd_second_i] = cmt_prd_second_i;
    srat_d = srat_q;
    if (excep_i) begin
      srat_d = arat_d;
    end else if (fire) begin
      if (alloc_first)  srat_d[rn_rd_first_i]  = prd_first;
      if (alloc_second) srat_d[rn_rd_second_i] = prd_second;
    end
  end

  // RAT state, identity mapping out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ARCH_REG_NUM; i++) begin
        srat_q[i] <= PHY_REG_WIDTH'(i);
        arat_q[i] <= PHY_REG_WIDTH'(i);
      end
    end else begin
      srat_q <= srat_d;
      arat_q <= arat_d;
    end
  end

  // Output register: load on fire, hold under backpressure, drop on flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_first_q  <= 1'b0;
      out_valid_second_q <= 1'b0;
      prs1_first_q       <= '0;
      prs2_first_q       <= '0;
      prd_first_q        <= '0;
      old_first_q        <= '0;
      prs1_second_q      <= '0;
      prs2_second_q      <= '0;
      prd_second_q       <= '0;
      old_second_q       <= '0;
    end else if (excep_i) begin
      out_valid_first_q  <= 1'b0;
      out_valid_second_q <= 1'b0;
    end else if (fire) begin
      out_valid_first_q  <= 1'b1;
      out_valid_second_q <= rn_valid_second_i;
      prs1_first_q       <= prs1_first;
      prs2_first_q       <= prs2_first;
      prd_first_q        <= prd_first;
      old_first_q        <= old_first;
      prs1_second_q      <= prs1_second;
      prs2_second_q      <= prs2_second;
      prd_second_q       <= prd_second;
      old_second_q       <= old_second;
    end else if (ds_ready_i) begin
      out_valid_first_q  <= 1'b0;
      out_valid_second_q <= 1'b0;
    end
  end

  assign out_valid_first_o    = out_valid_first_q;
  assign out_valid_second_o   = out_valid_second_q;
  assign out_prs1_first_o     = prs1_first_q;
  assign out_prs2_first_o     = prs2_first_q;
  assign out_prd_first_o      = prd_first_q;
  assign out_old_prd_first_o  = old_first_q;
  assign out_prs1_second_o    = prs1_second_q;
  assign out_prs2_second_o    = prs2_second_q;
  assign out_prd_second_o     = prd_second_q;
  assign out_old_prd_second_o = old_second_q;

endmodule

// File: tb/tb_rename_rat.sv
// Directed bench for rename_rat: table of cycle vectors plus short corner sequences.
module tb_rename_rat;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;

  logic clk, rst;
  logic rn_valid_first_i, rn_valid_second_i, rn_ready_o;
  logic [AW-1:0] rn_rs1_first_i, rn_rs2_first_i, rn_rd_first_i;
  logic [AW-1:0] rn_rs1_second_i, rn_rs2_second_i, rn_rd_second_i;
  logic rn_rd_wen_first_i, rn_rd_wen_second_i, ds_ready_i;
  logic out_valid_first_o, out_valid_second_o;
  logic [PW-1:0] out_prs1_first_o, out_prs2_first_o, out_prd_first_o, out_old_prd_first_o;
  logic [PW-1:0] out_prs1_second_o, out_prs2_second_o, out_prd_second_o, out_old_prd_second_o;
  logic fl_rd_first_en_o, fl_rd_second_en_o;
  logic [PW-1:0] fl_rdata_first_i, fl_rdata_second_i;
  logic fl_empty_i, fl_almost_empty_i;
  logic fl_wr_first_en_o, fl_wr_second_en_o;
  logic [PW-1:0] fl_wdata_first_o, fl_wdata_second_o;
  logic fl_rd_excep_first_en_o, fl_rd_excep_second_en_o, fl_excep_rst_o;
  logic cmt_valid_first_i, cmt_valid_second_i, cmt_rd_wen_first_i, cmt_rd_wen_second_i;
  logic [AW-1:0] cmt_rd_first_i, cmt_rd_second_i;
  logic [PW-1:0] cmt_prd_first_i, cmt_prd_second_i, cmt_old_prd_first_i, cmt_old_prd_second_i;
  logic excep_i;

  rename_rat dut (
    .clk(clk), .rst(rst),
    .rn_valid_first_i(rn_valid_first_i), .rn_valid_second_i(rn_valid_second_i),
    .rn_ready_o(rn_ready_o),
    .rn_rs1_first_i(rn_rs1_first_i), .rn_rs2_first_i(rn_rs2_first_i),
    .rn_rd_first_i(rn_rd_first_i),
    .rn_rs1_second_i(rn_rs1_second_i), .rn_rs2_second_i(rn_rs2_second_i),
    .rn_rd_second_i(rn_rd_second_i),
    .rn_rd_wen_first_i(rn_rd_wen_first_i), .rn_rd_wen_second_i(rn_rd_wen_second_i),
    .ds_ready_i(ds_ready_i),
    .out_valid_first_o(out_valid_first_o), .out_valid_second_o(out_valid_second_o),
    .out_prs1_first_o(out_prs1_first_o), .out_prs2_first_o(out_prs2_first_o),
    .out_prd_first_o(out_prd_first_o), .out_old_prd_first_o(out_old_prd_first_o),
    .out_prs1_second_o(out_prs1_second_o), .out_prs2_second_o(out_prs2_second_o),
    .out_prd_second_o(out_prd_second_o), .out_old_prd_second_o(out_old_prd_second_o),
    .fl_rd_first_en_o(fl_rd_first_en_o), .fl_rd_second_en_o(fl_rd_second_en_o),
    .fl_rdata_first_i(fl_rdata_first_i), .fl_rdata_second_i(fl_rdata_second_i),
    .fl_empty_i(fl_empty_i), .fl_almost_empty_i(fl_almost_empty_i),
    .fl_wr_first_en_o(fl_wr_first_en_o), .fl_wr_second_en_o(fl_wr_second_en_o),
    .fl_wdata_first_o(fl_wdata_first_o), .fl_wdata_second_o(fl_wdata_second_o),
    .fl_rd_excep_first_en_o(fl_rd_excep_first_en_o),
    .fl_rd_excep_second_en_o(fl_rd_excep_second_en_o),
    .fl_excep_rst_o(fl_excep_rst_o),
    .cmt_valid_first_i(cmt_valid_first_i), .cmt_valid_second_i(cmt_valid_second_i),
    .cmt_rd_wen_first_i(cmt_rd_wen_first_i), .cmt_rd_wen_second_i(cmt_rd_wen_second_i),
    .cmt_rd_first_i(cmt_rd_first_i), .cmt_rd_second_i(cmt_rd_second_i),
    .cmt_prd_first_i(cmt_prd_first_i), .cmt_prd_second_i(cmt_prd_second_i),
    .cmt_old_prd_first_i(cmt_old_prd_first_i), .cmt_old_prd_second_i(cmt_old_prd_second_i),
    .excep_i(excep_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    // stimulus
    logic v1, v2, wa, wb, ds, almost, excep, cv1, cv2;
    logic [AW-1:0] rs1a, rs2a, rda, rs1b, rs2b, rdb, crd1, crd2;
    logic [PW-1:0] fl1, fl2, cprd1, cold1, cprd2, cold2;
    // expected combinational outputs before the edge
    logic e_ready, e_pop1, e_pop2, e_wr1, e_wr2, e_exrst;
    logic [PW-1:0] e_wdata1, e_wdata2;
    // expected registered outputs after the edge
    logic e_ov1, e_ov2, chk;
    logic [PW-1:0] e_prs1a, e_prs2a, e_prda, e_olda, e_prs1b, e_prs2b, e_prdb, e_oldb;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_t(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rn_valid_first_i    = v.v1;   rn_valid_second_i   = v.v2;
    rn_rs1_first_i      = v.rs1a; rn_rs2_first_i      = v.rs2a; rn_rd_first_i  = v.rda;
    rn_rs1_second_i     = v.rs1b; rn_rs2_second_i     = v.rs2b; rn_rd_second_i = v.rdb;
    rn_rd_wen_first_i   = v.wa;   rn_rd_wen_second_i  = v.wb;
    ds_ready_i          = v.ds;
    fl_rdata_first_i    = v.fl1;  fl_rdata_second_i   = v.fl2;
    fl_almost_empty_i   = v.almost; fl_empty_i = 1'b0;
    cmt_valid_first_i   = v.cv1;  cmt_rd_wen_first_i  = v.cv1;
    cmt_valid_second_i  = v.cv2;  cmt_rd_wen_second_i = v.cv2;
    cmt_rd_first_i      = v.crd1; cmt_prd_first_i     = v.cprd1; cmt_old_prd_first_i  = v.cold1;
    cmt_rd_second_i     = v.crd2; cmt_prd_second_i    = v.cprd2; cmt_old_prd_second_i = v.cold2;
    excep_i             = v.excep;
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    chk_b({nm, ".ready"}, rn_ready_o, v.e_ready);
    chk_b({nm, ".pop1"}, fl_rd_first_en_o, v.e_pop1);
    chk_b({nm, ".pop2"}, fl_rd_second_en_o, v.e_pop2);
    chk_b({nm, ".wr1"}, fl_wr_first_en_o, v.e_wr1);
    chk_b({nm, ".wr2"}, fl_wr_second_en_o, v.e_wr2);
    chk_b({nm, ".cpop1"}, fl_rd_excep_first_en_o, v.e_wr1);
    chk_b({nm, ".cpop2"}, fl_rd_excep_second_en_o, v.e_wr2);
    chk_b({nm, ".exrst"}, fl_excep_rst_o, v.e_exrst);
    if (v.e_wr1) chk_t({nm, ".wdata1"}, fl_wdata_first_o, v.e_wdata1);
    if (v.e_wr2) chk_t({nm, ".wdata2"}, fl_wdata_second_o, v.e_wdata2);
    @(posedge clk);
    #1;
    chk_b({nm, ".ov1"}, out_valid_first_o, v.e_ov1);
    chk_b({nm, ".ov2"}, out_valid_second_o, v.e_ov2);
    if (v.chk) begin
      chk_t({nm, ".prs1a"}, out_prs1_first_o, v.e_prs1a);
      chk_t({nm, ".prs2a"}, out_prs2_first_o, v.e_prs2a);
      chk_t({nm, ".prda"}, out_prd_first_o, v.e_prda);
      chk_t({nm, ".olda"}, out_old_prd_first_o, v.e_olda);
      chk_t({nm, ".prs1b"}, out_prs1_second_o, v.e_prs1b);
      chk_t({nm, ".prs2b"}, out_prs2_second_o, v.e_prs2b);
      chk_t({nm, ".prdb"}, out_prd_second_o, v.e_prdb);
      chk_t({nm, ".oldb"}, out_old_prd_second_o, v.e_oldb);
    end
  endtask

  vec_t vecs [12];
  vec_t hs;
  vec_t idle;

  initial begin
    // Main table; each entry is one cycle and builds on the RAT state left by the previous.
    vecs[0]  = '{v1:1, rs1a:1, rs2a:2, rda:3, wa:1, fl1:40, ds:1, e_ready:1, e_pop1:1,
                 e_ov1:1, chk:1, e_prs1a:1, e_prs2a:2, e_prda:40, e_olda:3, default:0};
    vecs[1]  = '{v1:1, rs1a:3, rda:5, wa:1, v2:1, rs1b:5, rs2b:3, rdb:5, wb:1, fl1:41, fl2:42,
                 ds:1, e_ready:1, e_pop1:1, e_pop2:1, e_ov1:1, e_ov2:1, chk:1,
                 e_prs1a:40, e_prda:41, e_olda:5, e_prs1b:41, e_prs2b:40, e_prdb:42,
                 e_oldb:41, default:0};
    vecs[2]  = '{v1:1, rs1a:5, rda:0, wa:1, v2:1, rs1b:7, rs2b:1, rdb:7, wb:1, fl1:43, fl2:44,
                 ds:1, e_ready:1, e_pop1:1, e_ov1:1, e_ov2:1, chk:1, e_prs1a:42,
                 e_prs1b:7, e_prs2b:1, e_prdb:43, e_oldb:7, default:0};
    vecs[3]  = '{v1:1, rda:8, wa:1, fl1:50, ds:1, almost:1, default:0};
    vecs[4]  = '{v1:1, rs1a:7, rs2a:5, rda:9, ds:1, e_ready:1, e_ov1:1, chk:1,
                 e_prs1a:43, e_prs2a:42, default:0};
    for (int i = 5; i < 8; i++)
      vecs[i] = '{v1:1, rs1a:1, rda:10, wa:1, fl1:45, e_ov1:1, chk:1,
                  e_prs1a:43, e_prs2a:42, default:0};
    vecs[8]  = '{ds:1, e_ready:1, default:0};
    vecs[9]  = '{ds:1, cv1:1, crd1:3, cprd1:40, cold1:3, e_ready:1, e_wr1:1, e_wdata1:3,
                 default:0};
    vecs[10] = '{ds:1, excep:1, v1:1, rda:11, wa:1, fl1:46, e_exrst:1, default:0};
    vecs[11] = '{v1:1, rs1a:3, rs2a:5, rda:7, wa:1, v2:1, rs1b:7, rs2b:9, fl1:46, fl2:47,
                 ds:1, e_ready:1, e_pop1:1, e_ov1:1, e_ov2:1, chk:1, e_prs1a:40, e_prs2a:5,
                 e_prda:46, e_olda:7, e_prs1b:46, e_prs2b:9, default:0};
    idle     = '{ds:1, default:0};

    rst = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset.ov1", out_valid_first_o, 1'b0);
    chk_b("reset.ov2", out_valid_second_o, 1'b0);
    chk_t("reset.prda", out_prd_first_o, 6'd0);
    chk_t("reset.prs1b", out_prs1_second_o, 6'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Both commit slots hit x12 during a flush: slot 2 wins and the restore sees it.
    hs = '{ds:1, excep:1, cv1:1, crd1:12, cprd1:50, cold1:12, cv2:1, crd2:12, cprd2:51,
           cold2:50, e_exrst:1, e_wr1:1, e_wdata1:12, e_wr2:1, e_wdata2:50, default:0};
    apply(hs, "cmt2_excep");
    // Lone second commit compacts onto the first port.
    hs = '{ds:1, cv2:1, crd2:13, cprd2:52, cold2:13, v1:1, rs1a:12, rs2a:3, e_ready:1,
           e_wr1:1, e_wdata1:13, e_ov1:1, chk:1, e_prs1a:51, e_prs2a:40, default:0};
    apply(hs, "cmt_second_only");
    // Rename and commit to x14 in the same cycle.
    hs = '{ds:1, v1:1, rs1a:13, rda:14, wa:1, fl1:53, cv1:1, crd1:14, cprd1:54, cold1:14,
           e_ready:1, e_pop1:1, e_wr1:1, e_wdata1:14, e_ov1:1, chk:1, e_prs1a:13,
           e_prda:53, e_olda:14, default:0};
    apply(hs, "fire_cmt_same");
    hs = '{ds:1, v1:1, rs1a:14, e_ready:1, e_ov1:1, chk:1, e_prs1a:53, default:0};
    apply(hs, "srat_x14");
    hs = '{ds:1, excep:1, e_exrst:1, default:0};
    apply(hs, "excep2");
    hs = '{ds:1, v1:1, rs1a:14, rs2a:13, e_ready:1, e_ov1:1, chk:1, e_prs1a:54, e_prs2a:52,
           default:0};
    apply(hs, "arat_x14");

    // Asynchronous reset in the middle of a held bundle.
    @(negedge clk);
    drive('{v1:1, rs1a:14, rda:4, wa:1, fl1:60, default:0});
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_b("async_rst.ov1", out_valid_first_o, 1'b0);
    chk_t("async_rst.prs1a", out_prs1_first_o, 6'd0);
    chk_t("async_rst.prda", out_prd_first_o, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    hs = '{ds:1, v1:1, rs1a:3, rs2a:12, rda:14, e_ready:1, e_ov1:1, chk:1, e_prs1a:3,
           e_prs2a:12, default:0};
    apply(hs, "post_rst_identity");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_rat.md
Name: rename_rat

Overview:
- Two-wide register-rename stage; sits directly downstream of the physical-register freelist.
- Keeps a speculative RAT and an architectural RAT.
- Pops new physical tags from the freelist at rename; pushes stale tags back at commit.
- On exception, restores the speculative RAT from the architectural RAT and pulses the freelist exception reset.

Parameters:
ARCH_REG_NUM, 32, number of architectural registers (x0 hard-wired).
ARCH_REG_WIDTH, 5, architectural index width.
PHY_REG_WIDTH, 6, physical tag width.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-low reset.
rn_valid_first_i / rn_valid_second_i  input  1 each  rename bundle slot valid; second only with first.
rn_ready_o  output  1  bundle accepted when rn_valid_first_i & rn_ready_o.
rn_rs1_first_i, rn_rs2_first_i, rn_rd_first_i (and _second_)  input  ARCH_REG_WIDTH each  architectural indices.
rn_rd_wen_first_i / rn_rd_wen_second_i  input  1 each  slot writes rd.
ds_ready_i  input  1  downstream accepts output register.
out_valid_first_o / out_valid_second_o  output  1 each  renamed slot valid.
out_prs1_*_o, out_prs2_*_o, out_prd_*_o, out_old_prd_*_o  output  PHY_REG_WIDTH each  renamed tags per slot.
fl_rd_first_en_o / fl_rd_second_en_o  output  1 each  freelist pop enables.
fl_rdata_first_i / fl_rdata_second_i  input  PHY_REG_WIDTH each  popped tags (combinational, valid only while enabled).
fl_empty_i, fl_almost_empty_i  input  1 each  freelist has 0 / at most 1 entry.
fl_wr_first_en_o / fl_wr_second_en_o  output  1 each  freelist push enables.
fl_wdata_first_o / fl_wdata_second_o  output  PHY_REG_WIDTH each  tags returned at commit.
fl_rd_excep_first_en_o / fl_rd_excep_second_en_o  output  1 each  committed-pointer advance.
fl_excep_rst_o  output  1  freelist read-pointer restore.
cmt_valid_first_i / cmt_valid_second_i  input  1 each  in-order commit slots.
cmt_rd_wen_*_i  input  1 each  committing slot writes rd.
cmt_rd_*_i  input  ARCH_REG_WIDTH each  committing architectural rd.
cmt_prd_*_i, cmt_old_prd_*_i  input  PHY_REG_WIDTH each  committing tags.
excep_i  input  1  flush request.

Behaviour:
- Reset (async, rst=0):
  - Both RATs set to identity (arch i -> phys i).
  - All out_valid_* = 0; all out_* tags = 0.
- Allocation:
  - A slot allocates only when valid & rd_wen & rd!=0.
  - Otherwise prd=0 and old_prd=0 for that slot.
- rn_ready_o = !excep_i & (ds_ready_i | !out_valid_first_o) & !fl_almost_empty_i. Conservative: at least 2 free tags are always required.
- Pop compaction:
  - Allocations always use the first freelist port first.
  - One allocation (either slot): fl_rd_first_en_o only.
  - Two allocations: both enables.
  - Pop enables are asserted only in a fire cycle.
- Intra-bundle bypass, slot 2:
  - Slot-2 rs1/rs2 equal to slot-1 allocating rd -> use slot-1 new prd.
  - Slot-2 old_prd, when rd matches slot-1 allocating rd -> slot-1 new prd.
  - On equal rds, sRAT ends with the slot-2 mapping.
- Source x0 always maps to tag 0.
- Latency: one cycle; outputs are registered on fire.
- Output register behaviour:
  - Holds while out_valid & !ds_ready_i.
  - Clears valid when ds_ready_i and no fire.
- Commit (each cycle):
  - For each slot with valid & rd_wen & rd!=0: aRAT[rd] <= prd.
  - Freelist push of old_prd, compacted onto the first port.
  - fl_rd_excep enables, compacted the same way (committed pop count).
  - Two commits to the same rd: slot 2 wins in aRAT.
- Exception (excep_i=1):
  - fl_excep_rst_o = excep_i, combinational.
  - No pops and no fire that cycle.
  - Next edge: sRAT <= aRAT including same-cycle commit updates; out_valid_* <= 0.
  - Commit pushes in that cycle still occur.
- Simultaneous fire and commit to the same arch reg:
  - sRAT takes the rename value.
  - aRAT takes the commit value.

Test Plan:
- Reset release, one bundle {rs1=1, rs2=2, rd=3 wen} with fl_rdata_first_i=40 -> next cycle prs1=1, prs2=2, prd=40, old_prd=3, fl_rd_first_en_o pulsed once.
- Bundle slot1 rd=5, slot2 rs1=5, rd=5; fl tags 41,42 -> slot2 prs1=41, old_prd=41, prd=42; a later read of x5 gives 42.
- Slot1 rd=0 wen, slot2 rd=7 wen, fl_rdata_first_i=43 -> only fl_rd_first_en_o; slot1 prd=0; slot2 prd=43.
- fl_almost_empty_i=1 -> rn_ready_o=0, no pop. ds_ready_i=0 with output valid -> outputs held stable for 3 cycles.
- Commit rd=3 prd=40 old=3, then excep_i -> fl_wr_first_en_o with data 3, fl_excep_rst_o=1, next cycle x3 maps to 40, x5 restored to 5, out_valid=0.
- Assert rst low mid-bundle -> outputs immediately cleared, RAT identity.
